clk_div_ring: RTL and testbench
===============================

Name: clk_div_ring

Overview:
- Parametrised, run-time-reprogrammable integer clock divider that generates a fabric pixel clock from the bit clock.
- Generalises the fixed 5-bit ring counter:
  - arbitrary divide ratio, changeable at run time at period boundaries;
  - clock-enable;
  - phase resync;
  - registered strobes that the serialiser gearbox uses to load and align.
- Sits in the bit-clock domain next to the reset synchronisers. Its output feeds the pixel domain and the DVI gearbox.

Parameters:
- W_DIV, 4, width of the divide-ratio field; legal ratios are 2 to 2^W_DIV-1.
- DIV_RESET, 5, divide ratio loaded at reset; must be in the legal range.

Ports:
- clk  in  1  bit clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion already synchronised to clk.
- en  in  1  count enable; when low, all state is frozen.
- sync  in  1  phase resync request; forces the next phase to 0.
- div_req  in  W_DIV  requested divide ratio.
- div_req_vld  in  1  request valid.
- div_req_rdy  out  1  request ready; high when no change is pending.
- clk_out  out  1  divided clock, registered.
- tick_rise  out  1  one-cycle strobe coincident with the first cycle of clk_out high.
- tick_last  out  1  one-cycle strobe coincident with the last bit-clock cycle of the period.
- phase  out  W_DIV  current phase, 0 to div_cur-1.
- div_cur  out  W_DIV  divide ratio currently in effect.

Behaviour:
- State: phase, div_cur, pend_vld, pend_div, clk_out, tick_rise, tick_last. All are registers, reset asynchronously on rst_n low.
- Reset values:
  - phase = DIV_RESET-1, div_cur = DIV_RESET;
  - pend_vld = 0, pend_div = 0;
  - clk_out = 0, tick_rise = 0, tick_last = 0;
  - div_req_rdy = 1, because it equals !pend_vld (combinational).
- Wrap condition: wrap = (phase == div_cur-1) | sync.
- Divide ratio used for the next period: d_next = (wrap & pend_vld) ? pend_div : div_cur.
- Next phase: phase_next = wrap ? 0 : phase+1.
- High count: hi(d) = (d+1)>>1. Odd ratios are high-biased, e.g. 5 gives 3 cycles high and 2 low.
- On each cycle with en=1:
  - phase <= phase_next.
  - If wrap & pend_vld: div_cur <= pend_div and pend_vld <= 0.
  - clk_out <= (phase_next < hi(d_next)).
  - tick_rise <= (phase_next == 0).
  - tick_last <= (phase_next == d_next-1).
- On each cycle with en=0:
  - phase, div_cur, pend_* and clk_out hold.
  - tick_rise and tick_last are 0 on the next cycle.
  - Requests are still accepted if div_req_rdy=1.
- First enabled cycle after reset gives phase=0, clk_out=1, tick_rise=1.
- Request handshake:
  - Acceptance occurs when div_req_vld & div_req_rdy.
  - On acceptance, pend_div <= max(div_req, 2) and pend_vld <= 1. Ratios 0 and 1 clamp to 2.
  - Latency: an accepted value takes effect at the first wrap in a cycle strictly after acceptance. A request accepted in a wrap cycle is applied at the following wrap.
  - While pend_vld=1, div_req_rdy=0 and further requests stall. There is no overwrite.
- sync:
  - Acts as a wrap irrespective of phase, so the period is truncated. clk_out may show a short high or low.
  - Applies any pending ratio.
  - Ignored when en=0.
- Timing guarantees: clk_out has no glitches because it is registered. Ratio changes never split a period except via sync.
- If sync and a natural wrap coincide: single wrap, identical result.
- Reset mid-operation: all state returns immediately to its reset values, and any pending request is discarded.
- Arithmetic: phase and div_cur are unsigned W_DIV. Compare hi() at W_DIV+1 bits to avoid overflow at 2^W_DIV-1.

Test Plan:
- Reset release, en=1, DIV_RESET=5: clk_out = 1,1,1,0,0 repeating; tick_rise at phase 0; tick_last at phase 4; period 5 cycles; div_req_rdy=1.
- Request 4 accepted at phase 1: div_req_rdy low until wrap; current period completes as 5 cycles; then clk_out = 1,1,0,0 and div_cur=4; div_req_rdy returns to 1.
- Request 1 with W_DIV=4: clamps to 2, giving clk_out = 1,0 and tick_rise every 2 cycles. Request 15: 8 high, 7 low.
- Second request while pending: vld held, rdy=0, no acceptance; accepted the cycle after the apply wrap and applied at the next wrap.
- en low for 3 cycles at phase 2: phase and clk_out hold, ticks 0; resumes at phase 3 with no period distortion. sync pulse at phase 3 of 5: next cycle phase=0, clk_out=1, tick_rise=1.
- rst_n asserted mid-period with a pending request: outputs return to their reset values asynchronously; after release the ratio is DIV_RESET, not the pending value.

Source files
------------

// File: rtl/clk_div_ring.sv
// ---------------------------------------------------------------------------
// clk_div_ring
//   Run-time reprogrammable integer clock divider in the bit-clock domain.
//   It produces a registered divided clock plus one-cycle strobes that the
//   serialiser gearbox uses to load and align. Ratio changes are applied at
//   period boundaries. A sync pulse truncates the current period and restarts
//   it at phase 0.
//
// Ports
//   clk          in   bit clock, rising edge
//   rst_n        in   asynchronous active-low reset (release synchronised)
//   en           in   count enable; low freezes the divider state
//   sync         in   phase resync request (forces next phase to 0)
//   div_req      in   requested divide ratio (0/1 clamp to 2)
//   div_req_vld  in   request valid
//   div_req_rdy  out  request ready (no change pending)
//   clk_out      out  divided clock, registered
//   tick_rise    out  strobe on first cycle of clk_out high (phase 0)
//   tick_last    out  strobe on last bit-clock cycle of the period
//   phase        out  current phase, 0 .. div_cur-1
//   div_cur      out  divide ratio currently in effect
// ---------------------------------------------------------------------------
module clk_div_ring #(
    parameter int W_DIV     = 4,
    parameter int DIV_RESET = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic [W_DIV-1:0] div_req,
    input  logic             div_req_vld,
    output logic             div_req_rdy,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_last,
    output logic [W_DIV-1:0] phase,
    output logic [W_DIV-1:0] div_cur
);

    localparam logic [W_DIV-1:0] DIV_RST   = W_DIV'(DIV_RESET);
    localparam logic [W_DIV-1:0] PHASE_RST = W_DIV'(DIV_RESET - 1);
    localparam logic [W_DIV-1:0] DIV_MIN   = W_DIV'(2);
    localparam logic [W_DIV-1:0] ONE       = W_DIV'(1);

    // High-time length of a period, rounded up so odd ratios are high-biased.
    // Evaluated one bit wider so the maximum ratio cannot overflow.
    function automatic logic [W_DIV:0] hi_cnt(input logic [W_DIV-1:0] d);
        logic [W_DIV:0] dx;
        dx = {1'b0, d} + (W_DIV+1)'(1);
        return dx >> 1;
    endfunction

    logic [W_DIV-1:0] phase_q, phase_d;
    logic [W_DIV-1:0] div_cur_q, div_cur_d;
    logic [W_DIV-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_last_q, tick_last_d;

    logic             wrap;
    logic             apply;
    logic             accept;
    logic [W_DIV-1:0] d_next;
    logic [W_DIV-1:0] phase_next;
    logic [W_DIV-1:0] req_clamped;

    // sync behaves exactly like a natural end of period, so a coincident
    // sync and natural wrap collapse into a single wrap.
    assign wrap        = (phase_q == (div_cur_q - ONE)) | sync;
    assign apply       = wrap & pend_vld_q;
    assign d_next      = apply ? pend_div_q : div_cur_q;
    assign phase_next  = wrap ? '0 : (phase_q + ONE);
    assign accept      = div_req_vld & ~pend_vld_q;
    assign req_clamped = (div_req < DIV_MIN) ? DIV_MIN : div_req;

    always_comb begin
        phase_d     = phase_q;
        div_cur_d   = div_cur_q;
        pend_div_d  = pend_div_q;
        pend_vld_d  = pend_vld_q;
        clk_out_d   = clk_out_q;
        tick_rise_d = 1'b0;
        tick_last_d = 1'b0;

        if (en) begin
            phase_d     = phase_next;
            clk_out_d   = ({1'b0, phase_next} < hi_cnt(d_next));
            tick_rise_d = (phase_next == '0);
            tick_last_d = (phase_next == (d_next - ONE));
            if (apply) begin
                div_cur_d  = pend_div_q;
                pend_vld_d = 1'b0;
            end
        end

        // Handshake runs regardless of en. A request accepted in a wrap
        // cycle is only seen by the following wrap because apply uses the
        // registered pend_vld_q. accept and apply never coincide.
        if (accept) begin
            pend_vld_d = 1'b1;
            pend_div_d = req_clamped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PHASE_RST;
            div_cur_q   <= DIV_RST;
            pend_div_q  <= '0;
            pend_vld_q  <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_last_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            div_cur_q   <= div_cur_d;
            pend_div_q  <= pend_div_d;
            pend_vld_q  <= pend_vld_d;
            clk_out_q   <= clk_out_d;
            tick_rise_q <= tick_rise_d;
            tick_last_q <= tick_last_d;
        end
    end

    assign div_req_rdy = ~pend_vld_q;
    assign clk_out     = clk_out_q;
    assign tick_rise   = tick_rise_q;
    assign tick_last   = tick_last_q;
    assign phase       = phase_q;
    assign div_cur     = div_cur_q;

endmodule

// File: tb/tb_clk_div_ring.sv
module tb_clk_div_ring;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         sync;
    logic [W-1:0] div_req;
    logic         div_req_vld;
    logic         div_req_rdy;
    logic         clk_out;
    logic         tick_rise;
    logic         tick_last;
    logic [W-1:0] phase;
    logic [W-1:0] div_cur;

    clk_div_ring #(.W_DIV(W), .DIV_RESET(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync        (sync),
        .div_req     (div_req),
        .div_req_vld (div_req_vld),
        .div_req_rdy (div_req_rdy),
        .clk_out     (clk_out),
        .tick_rise   (tick_rise),
        .tick_last   (tick_last),
        .phase       (phase),
        .div_cur     (div_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic         sync;
        logic [W-1:0] req;
        logic         vld;
        logic         e_clk;
        logic         e_tr;
        logic         e_tl;
        logic [W-1:0] e_ph;
        logic [W-1:0] e_dc;
        logic         e_rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Packed view of all outputs: {clk_out, tick_rise, tick_last, phase, div_cur, rdy}
    function automatic logic [11:0] pk(logic c, logic tr, logic tl,
                                       logic [W-1:0] ph, logic [W-1:0] dc, logic rdy);
        return {c, tr, tl, ph, dc, rdy};
    endfunction

    task automatic v(input logic e, input logic s, input logic [W-1:0] r, input logic vl,
                     input logic c, input logic tr, input logic tl,
                     input logic [W-1:0] ph, input logic [W-1:0] dc, input logic rdy);
        vec_t x;
        x.en = e; x.sync = s; x.req = r; x.vld = vl;
        x.e_clk = c; x.e_tr = tr; x.e_tl = tl; x.e_ph = ph; x.e_dc = dc; x.e_rdy = rdy;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [11:0] exp_v);
        logic [11:0] got;
        got = pk(clk_out, tick_rise, tick_last, phase, div_cur, div_req_rdy);
        n_checks++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got clk/tr/tl=%b%b%b ph=%0d dc=%0d rdy=%b, expected clk/tr/tl=%b%b%b ph=%0d dc=%0d rdy=%b",
                      name, got[11], got[10], got[9], got[8:5], got[4:1], got[0],
                      exp_v[11], exp_v[10], exp_v[9], exp_v[8:5], exp_v[4:1], exp_v[0]);
    endtask

    task automatic drive(input logic e, input logic s, input logic [W-1:0] r, input logic vl);
        en = e; sync = s; div_req = r; div_req_vld = vl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);

        // Vector table: inputs for one edge, expected outputs just after it.
        // Ratio 5 free running
        v(0,0, 0,0, 0,0,0, 4,5,1);
        v(1,0, 0,0, 1,1,0, 0,5,1);
        v(1,0, 0,0, 1,0,0, 1,5,1);
        v(1,0, 0,0, 1,0,0, 2,5,1);
        v(1,0, 0,0, 0,0,0, 3,5,1);
        v(1,0, 0,0, 0,0,1, 4,5,1);
        v(1,0, 0,0, 1,1,0, 0,5,1);
        v(1,0, 0,0, 1,0,0, 1,5,1);
        // Request 4 accepted at phase 1; period of 5 completes first
        v(1,0, 4,1, 1,0,0, 2,5,0);
        v(1,0, 0,0, 0,0,0, 3,5,0);
        v(1,0, 0,0, 0,0,1, 4,5,0);
        v(1,0, 0,0, 1,1,0, 0,4,1);
        v(1,0, 0,0, 1,0,0, 1,4,1);
        v(1,0, 0,0, 0,0,0, 2,4,1);
        v(1,0, 0,0, 0,0,1, 3,4,1);
        v(1,0, 0,0, 1,1,0, 0,4,1);
        // Request 2, then 7 held while pending: no overwrite, 7 taken after apply
        v(1,0, 2,1, 1,0,0, 1,4,0);
        v(1,0, 7,1, 0,0,0, 2,4,0);
        v(1,0, 7,1, 0,0,1, 3,4,0);
        v(1,0, 7,1, 1,1,0, 0,2,1);
        v(1,0, 7,1, 0,0,1, 1,2,0);
        v(1,0, 0,0, 1,1,0, 0,7,1);
        v(1,0, 0,0, 1,0,0, 1,7,1);
        v(1,0, 0,0, 1,0,0, 2,7,1);
        v(1,0, 0,0, 1,0,0, 3,7,1);
        v(1,0, 0,0, 0,0,0, 4,7,1);
        v(1,0, 0,0, 0,0,0, 5,7,1);
        v(1,0, 0,0, 0,0,1, 6,7,1);
        v(1,0, 0,0, 1,1,0, 0,7,1);
        // Request 1 clamps to 2; sync applies it immediately
        v(1,0, 1,1, 1,0,0, 1,7,0);
        v(1,1, 0,0, 1,1,0, 0,2,1);
        v(1,0, 0,0, 0,0,1, 1,2,1);
        v(1,0, 0,0, 1,1,0, 0,2,1);
        v(1,0, 0,0, 0,0,1, 1,2,1);
        // Request 15 accepted in a wrap cycle: applied at the following wrap
        v(1,0,15,1, 1,1,0, 0,2,0);
        v(1,0, 0,0, 0,0,1, 1,2,0);
        v(1,0, 0,0, 1,1,0, 0,15,1);
        // Ratio 15: phases 1..7 high, 8..14 low
        v(1,0, 0,0, 1,0,0, 1,15,1);
        v(1,0, 0,0, 1,0,0, 2,15,1);
        v(1,0, 0,0, 1,0,0, 3,15,1);
        v(1,0, 0,0, 1,0,0, 4,15,1);
        v(1,0, 0,0, 1,0,0, 5,15,1);
        v(1,0, 0,0, 1,0,0, 6,15,1);
        v(1,0, 0,0, 1,0,0, 7,15,1);
        v(1,0, 0,0, 0,0,0, 8,15,1);
        v(1,0, 0,0, 0,0,0, 9,15,1);
        v(1,0, 0,0, 0,0,0,10,15,1);
        v(1,0, 0,0, 0,0,0,11,15,1);
        v(1,0, 0,0, 0,0,0,12,15,1);
        v(1,0, 0,0, 0,0,0,13,15,1);
        v(1,0, 0,0, 0,0,1,14,15,1);
        v(1,0, 0,0, 1,1,0, 0,15,1);
        // Back to 5 via sync
        v(1,0, 5,1, 1,0,0, 1,15,0);
        v(1,1, 0,0, 1,1,0, 0,5,1);
        v(1,0, 0,0, 1,0,0, 1,5,1);
        v(1,0, 0,0, 1,0,0, 2,5,1);
        // en low 3 cycles at phase 2; sync ignored; request still accepted
        v(0,0, 0,0, 1,0,0, 2,5,1);
        v(0,1, 0,0, 1,0,0, 2,5,1);
        v(0,0, 3,1, 1,0,0, 2,5,0);
        v(1,0, 0,0, 0,0,0, 3,5,0);
        // sync at phase 3 of 5 restarts the period and applies pending 3
        v(1,1, 0,0, 1,1,0, 0,3,1);
        v(1,0, 0,0, 1,0,0, 1,3,1);
        v(1,0, 0,0, 0,0,1, 2,3,1);
        v(1,0, 0,0, 1,1,0, 0,3,1);
        v(1,0, 0,0, 1,0,0, 1,3,1);
        v(1,0, 0,0, 0,0,1, 2,3,1);
        // sync coincident with natural wrap: single wrap
        v(1,1, 0,0, 1,1,0, 0,3,1);

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", pk(0,0,0, 4'd4, 4'd5, 1));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].sync, vecs[i].req, vecs[i].vld);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                pk(vecs[i].e_clk, vecs[i].e_tr, vecs[i].e_tl, vecs[i].e_ph, vecs[i].e_dc, vecs[i].e_rdy));
        end

        // Asynchronous reset mid-period with a request pending
        drive(1, 0, 4'd9, 1);
        @(posedge clk);
        #1;
        chk("pre_reset_pending", pk(1,0,0, 4'd1, 4'd3, 0));
        drive(1, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", pk(0,0,0, 4'd4, 4'd5, 1));
        @(posedge clk);
        #1;
        chk("reset_held_edge", pk(0,0,0, 4'd4, 4'd5, 1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_first", pk(1,1,0, 4'd0, 4'd5, 1));
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_ph4", pk(0,0,1, 4'd4, 4'd5, 1));
        @(posedge clk);
        #1;
        chk("post_reset_no_pending", pk(1,1,0, 4'd0, 4'd5, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
